alu_exec_sequencer: RTL and testbench
=====================================

# alu_exec_sequencer

Control-side partner of the ALU datapath. Owns the architectural A, X, Y, SP and N/Z/C/V registers, fetches an immediate operand over a request/acknowledge handshake, and drives the ALU input-select, carry-select and opcode lines. It then writes the ALU result and flags back. It sits between the instruction decoder (start/opcode) and the combinational ALU wrapper (select/result).

## Interface
Parameters:
- RESET_SP, 8'hFF, reset value of SP.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin instruction; sampled only in IDLE
- opcode  in  8  6502 opcode, sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: instruction retired
- err  out  1  one-cycle pulse: unsupported opcode
- operand_req  out  1  immediate-byte request, held until acknowledged
- operand_ack  in  1  operand_data valid this cycle
- operand_data  in  8  immediate byte
- alu_in1_sel, alu_in2_sel  out  3  mux codes: 0=A 1=X 2=Y 3=data 4=SP 6=8'hFF 7=8'h00
- alu_carry_sel  out  2  0=force 0, 1=force 1, 2=status C
- alu_opcode  out  8  8'h00 NOP, 01 ADD (a+b+c), 02 SUB (a+~b+c), 03 AND, 04 OR, 05 XOR, 06 PASS_A
- alu_a, alu_x, alu_y, alu_sp, alu_data  out  8  register file and latched operand to the ALU
- alu_cin  out  1  status C
- alu_out  in  8  ALU result
- alu_cout  in  1  ALU carry out
- reg_a, reg_x, reg_y, reg_sp  out  8  architectural registers
- flag_n, flag_z, flag_c, flag_v  out  1  status flags

## Operation
- States: IDLE, FETCH, EXEC, DONE.
- IDLE to FETCH on start with an immediate opcode. IDLE to EXEC on start with an implied opcode. IDLE stays in IDLE with err=1 on an unsupported opcode; no register or flag changes.
- FETCH: operand_req=1. On operand_ack=1, latch operand_data into alu_data, drop operand_req, and go to EXEC.
- EXEC: drive selects and opcode; at the clock edge, write alu_out to the destination and update flags; go to DONE. In every other state the selects are 0 and alu_opcode is NOP.
- DONE: done=1; go to IDLE.
- Immediate ops (in1, in2, carry, op, destination):
  - ADC 69: A, data, C, ADD; write A.
  - SBC E9: A, data, C, SUB; write A.
  - AND 29: AND; write A.
  - ORA 09: OR; write A.
  - EOR 49: XOR; write A.
  - CMP C9: A, data, 1, SUB; no write.
  - CPX E0: X, data, 1, SUB; no write.
  - CPY C0: Y, data, 1, SUB; no write.
  - LDA A9, LDX A2, LDY A0: data, PASS_A; write the named register.
- Implied ops:
  - INX E8: X, 00, 1, ADD.
  - INY C8: Y, 00, 1, ADD.
  - DEX CA: X, FF, 0, ADD.
  - DEY 88: Y, FF, 0, ADD.
  - TAX AA, TAY A8, TXA 8A, TYA 98, TSX BA, TXS 9A: source, PASS_A.
- Flag rules:
  - N and Z come from alu_out on every op except TXS, which changes no flags.
  - C = alu_cout for ADC, SBC, CMP, CPX and CPY only.
  - V for ADC/SBC only: b' = data (ADC) or ~data (SBC); V = (A[7]==b'[7]) && (alu_out[7]!=A[7]).
  - All unlisted flags are held.
- Arithmetic is 8-bit modulo 256; there is no decimal mode.

## Timing
- Reset values: A=X=Y=0, SP=RESET_SP, N=Z=C=V=0. State is IDLE; busy, done, err and operand_req are 0; selects are 0; alu_opcode is NOP; alu_data=0.
- Implied op: start is sampled at edge 0. EXEC is the cycle after edge 0; the registers update at edge 1. done is high in the cycle after edge 1; the next start is accepted at edge 3.
- Immediate op with ack in the first FETCH cycle: FETCH is cycle 1, EXEC is cycle 2, done is high in cycle 3. Each cycle of ack delay adds one cycle.
- operand_req asserts in the first FETCH cycle and stays high until the edge that samples operand_ack=1. It is low the following cycle. operand_ack outside FETCH is ignored.
- start is ignored while busy=1.
- err is high in the cycle after the sampling edge; busy stays 0.
- rst has priority everywhere. Reset in FETCH drops operand_req at that edge. Reset in EXEC suppresses the writeback; registers take their reset values.

## Test plan
- Reset: hold rst for 2 cycles -> A=X=Y=0, SP=FF, all flags 0, busy=0, operand_req=0, alu_opcode=00.
- LDA #$50, then ADC #$50 with C=0 and ack in the first FETCH cycle -> A=$A0, N=1, V=1, C=0, Z=0; done exactly 3 cycles after the ADC start edge.
- SBC #$01 with A=$00, C=1 -> A=$FF, C=0, N=1, V=0. Then CMP #$FF -> Z=1, C=1, A unchanged at $FF.
- DEX from X=$00 -> X=$FF, N=1, Z=0. Then INX -> X=$00, Z=1, C unchanged. Then TXS -> SP=$00, flags unchanged.
- LDY #imm with operand_ack delayed 4 cycles -> operand_req high for exactly 5 cycles. Repeat with rst asserted in the third FETCH cycle -> operand_req drops, Y stays 0, no done pulse.
- Opcode $02 -> err pulse, busy=0, no register change. Pulse start on every cycle during an ADC -> exactly one done and one update.

Source files
------------

// File: rtl/alu_exec_sequencer.sv
// rtl/alu_exec_sequencer.sv - control sequencer for the 8-bit ALU datapath (6502 subset)
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start, opcode        : instruction launch from the decoder (sampled in IDLE)
//   busy, done, err      : status; done/err are one-cycle pulses
//   operand_req/ack/data : immediate-byte fetch handshake
//   alu_in1_sel/in2_sel  : ALU input mux codes
//   alu_carry_sel        : ALU carry-in select
//   alu_opcode           : ALU operation
//   alu_a/x/y/sp/data    : register file and latched operand towards the ALU
//   alu_cin              : status C towards the ALU
//   alu_out, alu_cout    : ALU result and carry out
//   reg_a/x/y/sp, flag_* : architectural state
module alu_exec_sequencer #(
  parameter logic [7:0] RESET_SP = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] opcode,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       operand_req,
  input  logic       operand_ack,
  input  logic [7:0] operand_data,
  output logic [2:0] alu_in1_sel,
  output logic [2:0] alu_in2_sel,
  output logic [1:0] alu_carry_sel,
  output logic [7:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_x,
  output logic [7:0] alu_y,
  output logic [7:0] alu_sp,
  output logic [7:0] alu_data,
  output logic       alu_cin,
  input  logic [7:0] alu_out,
  input  logic       alu_cout,
  output logic [7:0] reg_a,
  output logic [7:0] reg_x,
  output logic [7:0] reg_y,
  output logic [7:0] reg_sp,
  output logic       flag_n,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_v
);

  localparam logic [2:0] SEL_A  = 3'd0;
  localparam logic [2:0] SEL_X  = 3'd1;
  localparam logic [2:0] SEL_Y  = 3'd2;
  localparam logic [2:0] SEL_D  = 3'd3;
  localparam logic [2:0] SEL_SP = 3'd4;
  localparam logic [2:0] SEL_FF = 3'd6;
  localparam logic [2:0] SEL_00 = 3'd7;

  localparam logic [1:0] CIN_0 = 2'd0;
  localparam logic [1:0] CIN_1 = 2'd1;
  localparam logic [1:0] CIN_C = 2'd2;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h03;
  localparam logic [7:0] OP_OR   = 8'h04;
  localparam logic [7:0] OP_XOR  = 8'h05;
  localparam logic [7:0] OP_PASS = 8'h06;

  localparam logic [2:0] DST_NONE = 3'd0;
  localparam logic [2:0] DST_A    = 3'd1;
  localparam logic [2:0] DST_X    = 3'd2;
  localparam logic [2:0] DST_Y    = 3'd3;
  localparam logic [2:0] DST_SP   = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  // Everything EXEC needs; latched at start so the opcode input is free afterwards.
  typedef struct packed {
    logic [2:0] in1;
    logic [2:0] in2;
    logic [1:0] csel;
    logic [7:0] op;
    logic [2:0] dest;
    logic       upd_nz;
    logic       upd_c;
    logic       upd_v;
    logic       v_sub;  // overflow uses the inverted operand (SBC)
  } exec_t;

  typedef struct packed {
    logic  valid;
    logic  imm;
    exec_t ex;
  } dec_t;

  function automatic exec_t mk(input logic [2:0] in1, input logic [2:0] in2,
                               input logic [1:0] csel, input logic [7:0] op,
                               input logic [2:0] dest, input logic nz,
                               input logic c, input logic v, input logic vs);
    exec_t e;
    e.in1 = in1; e.in2 = in2; e.csel = csel; e.op = op; e.dest = dest;
    e.upd_nz = nz; e.upd_c = c; e.upd_v = v; e.v_sub = vs;
    return e;
  endfunction

  function automatic dec_t decode(input logic [7:0] op);
    dec_t d;
    d = '0;
    d.valid = 1'b1;
    d.imm   = 1'b1;
    case (op)
      8'h69: d.ex = mk(SEL_A,  SEL_D,  CIN_C, OP_ADD,  DST_A,    1'b1, 1'b1, 1'b1, 1'b0);
      8'hE9: d.ex = mk(SEL_A,  SEL_D,  CIN_C, OP_SUB,  DST_A,    1'b1, 1'b1, 1'b1, 1'b1);
      8'h29: d.ex = mk(SEL_A,  SEL_D,  CIN_0, OP_AND,  DST_A,    1'b1, 1'b0, 1'b0, 1'b0);
      8'h09: d.ex = mk(SEL_A,  SEL_D,  CIN_0, OP_OR,   DST_A,    1'b1, 1'b0, 1'b0, 1'b0);
      8'h49: d.ex = mk(SEL_A,  SEL_D,  CIN_0, OP_XOR,  DST_A,    1'b1, 1'b0, 1'b0, 1'b0);
      8'hC9: d.ex = mk(SEL_A,  SEL_D,  CIN_1, OP_SUB,  DST_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
      8'hE0: d.ex = mk(SEL_X,  SEL_D,  CIN_1, OP_SUB,  DST_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
      8'hC0: d.ex = mk(SEL_Y,  SEL_D,  CIN_1, OP_SUB,  DST_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
      8'hA9: d.ex = mk(SEL_D,  SEL_A,  CIN_0, OP_PASS, DST_A,    1'b1, 1'b0, 1'b0, 1'b0);
      8'hA2: d.ex = mk(SEL_D,  SEL_A,  CIN_0, OP_PASS, DST_X,    1'b1, 1'b0, 1'b0, 1'b0);
      8'hA0: d.ex = mk(SEL_D,  SEL_A,  CIN_0, OP_PASS, DST_Y,    1'b1, 1'b0, 1'b0, 1'b0);
      default: begin
        d.imm = 1'b0;
        case (op)
          8'hE8: d.ex = mk(SEL_X,  SEL_00, CIN_1, OP_ADD,  DST_X,  1'b1, 1'b0, 1'b0, 1'b0);
          8'hC8: d.ex = mk(SEL_Y,  SEL_00, CIN_1, OP_ADD,  DST_Y,  1'b1, 1'b0, 1'b0, 1'b0);
          8'hCA: d.ex = mk(SEL_X,  SEL_FF, CIN_0, OP_ADD,  DST_X,  1'b1, 1'b0, 1'b0, 1'b0);
          8'h88: d.ex = mk(SEL_Y,  SEL_FF, CIN_0, OP_ADD,  DST_Y,  1'b1, 1'b0, 1'b0, 1'b0);
          8'hAA: d.ex = mk(SEL_A,  SEL_A,  CIN_0, OP_PASS, DST_X,  1'b1, 1'b0, 1'b0, 1'b0);
          8'hA8: d.ex = mk(SEL_A,  SEL_A,  CIN_0, OP_PASS, DST_Y,  1'b1, 1'b0, 1'b0, 1'b0);
          8'h8A: d.ex = mk(SEL_X,  SEL_A,  CIN_0, OP_PASS, DST_A,  1'b1, 1'b0, 1'b0, 1'b0);
          8'h98: d.ex = mk(SEL_Y,  SEL_A,  CIN_0, OP_PASS, DST_A,  1'b1, 1'b0, 1'b0, 1'b0);
          8'hBA: d.ex = mk(SEL_SP, SEL_A,  CIN_0, OP_PASS, DST_X,  1'b1, 1'b0, 1'b0, 1'b0);
          8'h9A: d.ex = mk(SEL_X,  SEL_A,  CIN_0, OP_PASS, DST_SP, 1'b0, 1'b0, 1'b0, 1'b0);
          default: d.valid = 1'b0;
        endcase
      end
    endcase
    return d;
  endfunction

  state_t state, state_nxt;
  exec_t  ex_q;
  dec_t   dec_in;
  logic   b7;

  assign dec_in = decode(opcode);

  always_comb begin
    state_nxt     = state;
    alu_in1_sel   = SEL_A;
    alu_in2_sel   = SEL_A;
    alu_carry_sel = CIN_0;
    alu_opcode    = OP_NOP;
    case (state)
      S_IDLE: begin
        if (start && dec_in.valid) state_nxt = dec_in.imm ? S_FETCH : S_EXEC;
      end
      S_FETCH: begin
        if (operand_ack) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_in1_sel   = ex_q.in1;
        alu_in2_sel   = ex_q.in2;
        alu_carry_sel = ex_q.csel;
        alu_opcode    = ex_q.op;
        state_nxt     = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign operand_req = (state == S_FETCH);

  assign alu_a   = reg_a;
  assign alu_x   = reg_x;
  assign alu_y   = reg_y;
  assign alu_sp  = reg_sp;
  assign alu_cin = flag_c;

  // Sign bit of the effective second operand for overflow.
  assign b7 = ex_q.v_sub ? ~alu_data[7] : alu_data[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ex_q     <= '0;
      err      <= 1'b0;
      alu_data <= 8'h00;
      reg_a    <= 8'h00;
      reg_x    <= 8'h00;
      reg_y    <= 8'h00;
      reg_sp   <= RESET_SP;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= (state == S_IDLE) && start && !dec_in.valid;
      if (state == S_IDLE && start && dec_in.valid) ex_q <= dec_in.ex;
      if (state == S_FETCH && operand_ack) alu_data <= operand_data;
      if (state == S_EXEC) begin
        case (ex_q.dest)
          DST_A:   reg_a  <= alu_out;
          DST_X:   reg_x  <= alu_out;
          DST_Y:   reg_y  <= alu_out;
          DST_SP:  reg_sp <= alu_out;
          default: ;
        endcase
        if (ex_q.upd_nz) begin
          flag_n <= alu_out[7];
          flag_z <= (alu_out == 8'h00);
        end
        if (ex_q.upd_c) flag_c <= alu_cout;
        if (ex_q.upd_v) flag_v <= (reg_a[7] == b7) && (alu_out[7] != reg_a[7]);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb/tb_alu_exec_sequencer.sv - randomized self-checking bench for alu_exec_sequencer
module tb_alu_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] opcode;
  logic       busy, done, err, operand_req;
  logic       operand_ack;
  logic [7:0] operand_data;
  logic [2:0] alu_in1_sel, alu_in2_sel;
  logic [1:0] alu_carry_sel;
  logic [7:0] alu_opcode;
  logic [7:0] alu_a, alu_x, alu_y, alu_sp, alu_data;
  logic       alu_cin;
  logic [7:0] alu_out;
  logic       alu_cout;
  logic [7:0] reg_a, reg_x, reg_y, reg_sp;
  logic       flag_n, flag_z, flag_c, flag_v;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_a, m_x, m_y, m_sp;
  logic       m_n, m_z, m_c, m_v;

  logic [7:0] imm_ops [11] = '{8'h69, 8'hE9, 8'h29, 8'h09, 8'h49, 8'hC9, 8'hE0, 8'hC0, 8'hA9, 8'hA2, 8'hA0};
  logic [7:0] imp_ops [10] = '{8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hBA, 8'h9A};

  always #5 clk = ~clk;

  alu_exec_sequencer #(.RESET_SP(8'hFF)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .err(err),
    .operand_req(operand_req), .operand_ack(operand_ack), .operand_data(operand_data),
    .alu_in1_sel(alu_in1_sel), .alu_in2_sel(alu_in2_sel), .alu_carry_sel(alu_carry_sel),
    .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_x(alu_x), .alu_y(alu_y), .alu_sp(alu_sp), .alu_data(alu_data),
    .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout),
    .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y), .reg_sp(reg_sp),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  // Combinational ALU wrapper the sequencer talks to.
  function automatic logic [7:0] pick(input logic [2:0] sel);
    case (sel)
      3'd0: return alu_a;
      3'd1: return alu_x;
      3'd2: return alu_y;
      3'd3: return alu_data;
      3'd4: return alu_sp;
      3'd6: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] in1, in2;
  logic       cin;
  logic [8:0] sum;
  always_comb begin
    in1 = pick(alu_in1_sel);
    in2 = pick(alu_in2_sel);
    cin = (alu_carry_sel == 2'd1) ? 1'b1 : (alu_carry_sel == 2'd2) ? alu_cin : 1'b0;
    sum = 9'h000;
    case (alu_opcode)
      8'h01: sum = {1'b0, in1} + {1'b0, in2} + {8'h00, cin};
      8'h02: sum = {1'b0, in1} + {1'b0, ~in2} + {8'h00, cin};
      8'h03: sum = {1'b0, in1 & in2};
      8'h04: sum = {1'b0, in1 | in2};
      8'h05: sum = {1'b0, in1 ^ in2};
      8'h06: sum = {1'b0, in1};
      default: sum = 9'h000;
    endcase
    alu_out  = sum[7:0];
    alu_cout = sum[8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".a"}, reg_a, m_a);
    check({tag, ".x"}, reg_x, m_x);
    check({tag, ".y"}, reg_y, m_y);
    check({tag, ".sp"}, reg_sp, m_sp);
    check({tag, ".nzcv"}, {flag_n, flag_z, flag_c, flag_v}, {m_n, m_z, m_c, m_v});
  endtask

  task automatic model_reset();
    m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_sp = 8'hFF;
    m_n = 1'b0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
  endtask

  function automatic int sgn(input logic [7:0] v);
    return (v >= 8'd128) ? int'(v) - 256 : int'(v);
  endfunction

  task automatic set_nz(input logic [7:0] v);
    m_n = v[7];
    m_z = (v == 8'h00);
  endtask

  // 6502 instruction semantics in plain arithmetic.
  task automatic model_exec(input logic [7:0] op, input logic [7:0] d);
    int r, s;
    case (op)
      8'h69: begin
        r = int'(m_a) + int'(d) + int'(m_c);
        s = sgn(m_a) + sgn(d) + int'(m_c);
        m_c = (r > 255); m_v = (s > 127) || (s < -128); m_a = r[7:0]; set_nz(m_a);
      end
      8'hE9: begin
        r = int'(m_a) - int'(d) - (1 - int'(m_c));
        s = sgn(m_a) - sgn(d) - (1 - int'(m_c));
        m_c = (r >= 0); m_v = (s > 127) || (s < -128); m_a = r[7:0]; set_nz(m_a);
      end
      8'h29: begin m_a = m_a & d; set_nz(m_a); end
      8'h09: begin m_a = m_a | d; set_nz(m_a); end
      8'h49: begin m_a = m_a ^ d; set_nz(m_a); end
      8'hC9: begin m_c = (m_a >= d); set_nz(m_a - d); end
      8'hE0: begin m_c = (m_x >= d); set_nz(m_x - d); end
      8'hC0: begin m_c = (m_y >= d); set_nz(m_y - d); end
      8'hA9: begin m_a = d; set_nz(m_a); end
      8'hA2: begin m_x = d; set_nz(m_x); end
      8'hA0: begin m_y = d; set_nz(m_y); end
      8'hE8: begin m_x = m_x + 8'd1; set_nz(m_x); end
      8'hC8: begin m_y = m_y + 8'd1; set_nz(m_y); end
      8'hCA: begin m_x = m_x - 8'd1; set_nz(m_x); end
      8'h88: begin m_y = m_y - 8'd1; set_nz(m_y); end
      8'hAA: begin m_x = m_a; set_nz(m_x); end
      8'hA8: begin m_y = m_a; set_nz(m_y); end
      8'h8A: begin m_a = m_x; set_nz(m_a); end
      8'h98: begin m_a = m_y; set_nz(m_a); end
      8'hBA: begin m_x = m_sp; set_nz(m_x); end
      8'h9A: m_sp = m_x;
      default: ;
    endcase
  endtask

  function automatic bit is_imm(input logic [7:0] op);
    foreach (imm_ops[i]) if (imm_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_supported(input logic [7:0] op);
    foreach (imp_ops[i]) if (imp_ops[i] == op) return 1'b1;
    return is_imm(op);
  endfunction

  // Launch one supported instruction; optionally hammer start while busy.
  task automatic run_instr(input string tag, input logic [7:0] op, input logic [7:0] d,
                           input int delay, input bit hammer);
    int cyc, req_cnt, done_cyc, exp_lat;
    bit imm, err_seen;
    imm = is_imm(op);
    exp_lat = imm ? 3 + delay : 2;
    @(negedge clk);
    start = 1'b1; opcode = op; operand_ack = 1'b0;
    @(negedge clk);
    cyc = 1; req_cnt = 0; done_cyc = 0; err_seen = 1'b0;
    while (cyc < 60 && done_cyc == 0) begin
      if (operand_req) req_cnt++;
      if (err) err_seen = 1'b1;
      if (done) done_cyc = cyc;
      if (imm && cyc == 1 + delay) begin
        operand_ack = 1'b1; operand_data = d;
      end else if (imm && cyc < 1 + delay) begin
        operand_ack = 1'b0; operand_data = 8'($urandom);
      end else begin
        operand_ack = 1'($urandom_range(0, 1)); operand_data = 8'($urandom);
      end
      start  = hammer && !done;
      opcode = hammer ? 8'($urandom) : op;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; operand_ack = 1'b0;
    model_exec(op, d);
    check({tag, ".latency"}, done_cyc, exp_lat);
    check({tag, ".req_cycles"}, req_cnt, imm ? delay + 1 : 0);
    check({tag, ".no_err"}, err_seen, 0);
    check({tag, ".idle"}, {busy, done, operand_req, alu_opcode}, 0);
    check_regs(tag);
  endtask

  task automatic run_bad(input string tag, input logic [7:0] op);
    @(negedge clk);
    start = 1'b1; opcode = op;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".err_pulse"}, {err, busy, operand_req}, 3'b100);
    @(negedge clk);
    check({tag, ".err_end"}, {err, busy, done}, 3'b000);
    check_regs(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    int done_cnt;
    rst = 1'b1; start = 1'b0; opcode = 8'h00; operand_ack = 1'b0; operand_data = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset.regs", {reg_a, reg_x, reg_y, reg_sp}, 32'h0000_00FF);
    check("reset.flags", {flag_n, flag_z, flag_c, flag_v}, 0);
    check("reset.ctl", {busy, done, err, operand_req}, 0);
    check("reset.alu", {alu_opcode, alu_in1_sel, alu_in2_sel, alu_carry_sel, alu_data}, 0);

    run_instr("lda50", 8'hA9, 8'h50, 0, 0);
    run_instr("adc50", 8'h69, 8'h50, 0, 0);
    check("adc50.const", {reg_a, flag_n, flag_z, flag_c, flag_v}, {8'hA0, 4'b1001});

    run_instr("lda00", 8'hA9, 8'h00, 0, 0);
    run_instr("cmp00", 8'hC9, 8'h00, 0, 0);
    run_instr("sbc01", 8'hE9, 8'h01, 0, 0);
    check("sbc01.const", {reg_a, flag_n, flag_c, flag_v}, {8'hFF, 3'b100});
    run_instr("cmpff", 8'hC9, 8'hFF, 1, 0);
    check("cmpff.const", {reg_a, flag_z, flag_c}, {8'hFF, 2'b11});

    run_instr("ldx00", 8'hA2, 8'h00, 0, 0);
    run_instr("dex", 8'hCA, 8'h00, 0, 0);
    check("dex.const", {reg_x, flag_n, flag_z}, {8'hFF, 2'b10});
    run_instr("inx", 8'hE8, 8'h00, 0, 0);
    check("inx.const", {reg_x, flag_z, flag_c}, {8'h00, 2'b11});
    run_instr("txs", 8'h9A, 8'h00, 0, 0);
    check("txs.const", {reg_sp, flag_n, flag_z, flag_c, flag_v}, {8'h00, 4'b0110});

    run_instr("ldy_slow", 8'hA0, 8'h33, 4, 0);

    // Reset during the third FETCH cycle.
    @(negedge clk);
    start = 1'b1; opcode = 8'hA0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rstfetch.req", operand_req, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rstfetch.req_drop", {operand_req, busy}, 0);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      operand_ack = 1'b1; operand_data = 8'h77;
      if (done) done_cnt++;
      @(negedge clk);
    end
    operand_ack = 1'b0;
    check("rstfetch.no_done", done_cnt, 0);
    check_regs("rstfetch");

    run_bad("bad02", 8'h02);
    run_instr("adc_hammer", 8'h69, 8'($urandom), 0, 1);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check("adc_hammer.quiet", done_cnt, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        if ($urandom_range(0, 1) == 1) op = imm_ops[$urandom_range(0, 10)];
        else op = imp_ops[$urandom_range(0, 9)];
        run_instr("rnd", op, 8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else begin
        op = 8'($urandom);
        while (is_supported(op)) op = 8'($urandom);
        run_bad("rnd_bad", op);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
